// File: rtl/store_pkg.sv
// Shared store-path definitions: funct3 store encodings, FSM states and a
// helper that maps a store encoding to its byte count.
package store_pkg;

    localparam logic [2:0] SEL_SB = 3'b000;
    localparam logic [2:0] SEL_SH = 3'b001;
    localparam logic [2:0] SEL_SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } state_t;

    // Returns 0 for an unsupported encoding so callers can treat it as invalid.
    function automatic logic [2:0] sel_bytes(input logic [2:0] sel);
        case (sel)
            SEL_SB:  return 3'd1;
            SEL_SH:  return 3'd2;
            SEL_SW:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Core-side store request and word-addressed memory write port of store_unit.
// STORE_MISALIGN_TRAP_EN adds the st_misalign pulse.
interface store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [2:0]        store_sel;
    logic              st_done;
    logic              st_err;
`ifdef STORE_MISALIGN_TRAP_EN
    logic              st_misalign;
`endif

    logic              mem_req;
    logic              mem_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;

    modport slave (
        input  st_valid, st_addr, st_data, store_sel, mem_gnt,
`ifdef STORE_MISALIGN_TRAP_EN
        output st_misalign,
`endif
        output st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output st_valid, st_addr, st_data, store_sel, mem_gnt,
`ifdef STORE_MISALIGN_TRAP_EN
        input  st_misalign,
`endif
        input  st_ready, st_done, st_err, mem_req, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/store_align.sv
// Combinational lane alignment: places the low 1/2/4 store bytes at the byte
// offset and splits the result into two word beats with their byte enables.
module store_align
    import store_pkg::*;
(
    input  logic [31:0] i_st_data,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_sel,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic [31:0] o_wdata0,
    output logic [31:0] o_wdata1,
    output logic        o_split
);

    logic [3:0]  w_nmask;
    logic [31:0] w_data;
    logic [7:0]  w_mask8;
    logic [63:0] w_data64;

    always_comb begin
        // NOTE: every signal gets a value before the case so no path leaves it unassigned (no latch).
        w_nmask = 4'b0000;
        case (sel_bytes(i_sel))
            3'd1:    w_nmask = 4'b0001;
            3'd2:    w_nmask = 4'b0011;
            3'd4:    w_nmask = 4'b1111;
            default: w_nmask = 4'b0000;
        endcase
        w_data   = i_st_data & {{8{w_nmask[3]}}, {8{w_nmask[2]}},
                                {8{w_nmask[1]}}, {8{w_nmask[0]}}};
        w_mask8  = {4'b0000, w_nmask} << i_off;
        w_data64 = {32'd0, w_data} << {i_off, 3'b000};
    end

    assign o_be0    = w_mask8[3:0];
    assign o_be1    = w_mask8[7:4];
    assign o_wdata0 = w_data64[31:0];
    assign o_wdata1 = w_data64[63:32];
    assign o_split  = |w_mask8[7:4];

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts SB/SH/SW, aligns data to byte lanes and writes one or two
// words over a req/gnt port. STORE_MISALIGN_TRAP_EN traps misaligned stores instead.
module store_unit
    import store_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    store_unit_if.slave   bus
);

    state_t              r_state;
    logic                r_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_be;
    logic [DATA_W-1:0]   r_wdata1;
    logic [3:0]          r_be1;
    logic                r_split;
    logic                r_done;
    logic                r_err;
`ifdef STORE_MISALIGN_TRAP_EN
    logic                r_misalign;
    logic                w_misalign;
`endif

    logic [2:0]  w_n;
    logic        w_sel_ok;
    logic [3:0]  w_be0, w_be1;
    logic [31:0] w_wdata0, w_wdata1;
    logic        w_split;

    store_align u_align (
        .i_st_data (bus.st_data),
        .i_off     (bus.st_addr[1:0]),
        .i_sel     (bus.store_sel),
        .o_be0     (w_be0),
        .o_be1     (w_be1),
        .o_wdata0  (w_wdata0),
        .o_wdata1  (w_wdata1),
        .o_split   (w_split)
    );

    assign w_n      = sel_bytes(bus.store_sel);
    assign w_sel_ok = (w_n != 3'd0);
`ifdef STORE_MISALIGN_TRAP_EN
    // Misaligned: crosses a word, or offset is not a multiple of the size.
    assign w_misalign = w_split | (|(bus.st_addr[1:0] & 2'(w_n - 3'd1)));
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= 4'b0000;
            r_wdata1   <= '0;
            r_be1      <= 4'b0000;
            r_split    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (bus.st_valid) begin
                        if (!w_sel_ok) begin
                            r_err <= 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
                        end else if (w_misalign) begin
                            r_misalign <= 1'b1;
`endif
                        end else begin
                            r_state  <= WR0;
                            r_req    <= 1'b1;
                            r_addr   <= {bus.st_addr[ADDR_W-1:2], 2'b00};
                            r_be     <= w_be0;
                            r_wdata  <= w_wdata0;
                            r_be1    <= w_be1;
                            r_wdata1 <= w_wdata1;
                            r_split  <= w_split;
                        end
                    end
                end
                WR0: begin
                    if (bus.mem_gnt) begin
                        if (r_split) begin
                            r_state <= WR1;
                            r_addr  <= r_addr + ADDR_W'(4);
                            r_be    <= r_be1;
                            r_wdata <= r_wdata1;
                        end else begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                            r_be    <= 4'b0000;
                            r_done  <= 1'b1;
                        end
                    end
                end
                WR1: begin
                    if (bus.mem_gnt) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                        r_be    <= 4'b0000;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.st_ready  = (r_state == IDLE);
    assign bus.st_done   = r_done;
    assign bus.st_err    = r_err;
    assign bus.mem_req   = r_req;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_be    = r_be;
`ifdef STORE_MISALIGN_TRAP_EN
    assign bus.st_misalign = r_misalign;
`endif

endmodule
